video_oam_dma: RTL and testbench

- Bus initiator that performs sprite DMA: a CPU write to the DMA page register copies 256 bytes from CPU page XX00-XXFF into the PPU's OAMDATA register ($2004).
- Sits on the host bus between the CPU core and the PPU register port. It halts the CPU through RDY, takes bus ownership, and issues 256 alternating read/write bus cycles.
- Each OAMDATA write is a separate wren assertion, so the PPU's rising-edge register decode increments OAM address once per byte.

---
 rtl/video_oam_dma.sv | 167 ++++++++++++++++
 tb/tb_video_oam_dma.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_oam_dma.sv
// video_oam_dma -- sprite DMA bus initiator.
//
// A CPU write to the DMA page register starts a copy of P_count bytes from
// CPU page {page, 00}..{page, P_count-1} into the PPU OAMDATA port. The block
// stalls the CPU through O_cpu_rdy, takes the bus and alternates read and
// write bus cycles. Every state change happens on a clock where I_tick=1, so
// each output value lasts for exactly one CPU bus cycle.
//
// Ports:
//   I_clock, I_reset       clock, synchronous active-high reset
//   I_tick                 one-clock strobe at the end of each CPU bus cycle
//   I_reg_wren, I_reg_data CPU write to the DMA page register and its page
//   I_cpu_read             CPU is doing a read cycle (RDY only stalls reads)
//   O_cpu_rdy              0 stalls the CPU
//   O_busy                 transfer in progress
//   O_bus_req              DMA owns the bus
//   O_bus_addr             DMA bus address
//   O_bus_rden, O_bus_wren DMA read / write cycle
//   I_bus_data             read data from the bus
//   O_bus_data             write data for the bus
module video_oam_dma #(
  parameter logic [15:0] P_oam_port = 16'h2004,
  parameter int          P_count    = 256
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_tick,
  input  logic        I_reg_wren,
  input  logic [7:0]  I_reg_data,
  input  logic        I_cpu_read,
  output logic        O_cpu_rdy,
  output logic        O_busy,
  output logic        O_bus_req,
  output logic [15:0] O_bus_addr,
  output logic        O_bus_rden,
  output logic        O_bus_wren,
  input  logic [7:0]  I_bus_data,
  output logic [7:0]  O_bus_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(P_count - 1);

  state_t      state_reg, state_next;
  logic [7:0]  page_reg, page_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  data_reg, data_next;
  logic        parity_reg, parity_next;

  logic        cpu_rdy_reg, cpu_rdy_next;
  logic        busy_reg, busy_next;
  logic        bus_req_reg, bus_req_next;
  logic [15:0] bus_addr_reg, bus_addr_next;
  logic        bus_rden_reg, bus_rden_next;
  logic        bus_wren_reg, bus_wren_next;
  logic [7:0]  bus_data_reg, bus_data_next;

  // Next-state logic. Nothing moves unless I_tick is high.
  always_comb begin
    state_next  = state_reg;
    page_next   = page_reg;
    idx_next    = idx_reg;
    data_next   = data_reg;
    parity_next = parity_reg;

    if (I_tick) begin
      parity_next = ~parity_reg;
      unique case (state_reg)
        ST_IDLE: begin
          if (I_reg_wren) begin
            page_next  = I_reg_data;
            idx_next   = 8'd0;
            state_next = ST_HALT;
          end
        end
        ST_HALT: begin
          // The CPU is only really stopped once it hits a read cycle. Reads
          // must land on get cycles (parity 0); the coming cycle has parity
          // ~parity_reg, so an extra ALIGN cycle is needed when that is 1.
          if (I_cpu_read) begin
            state_next = parity_reg ? ST_READ : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          state_next = ST_READ;
        end
        ST_READ: begin
          data_next  = I_bus_data;
          state_next = ST_WRITE;
        end
        ST_WRITE: begin
          idx_next   = 8'(idx_reg + 8'd1);
          state_next = (idx_reg == LAST_IDX) ? ST_IDLE : ST_READ;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs are a pure function of the upcoming state, so they
  // change together with the state and stay put for the whole bus cycle.
  always_comb begin
    cpu_rdy_next  = (state_next == ST_IDLE);
    busy_next     = (state_next != ST_IDLE);
    bus_req_next  = (state_next == ST_ALIGN) || (state_next == ST_READ) ||
                    (state_next == ST_WRITE);
    bus_rden_next = (state_next == ST_READ);
    bus_wren_next = (state_next == ST_WRITE);
    bus_addr_next = 16'h0000;
    bus_data_next = 8'h00;
    if (state_next == ST_READ) begin
      // Read address stays inside the latched page; idx wraps at 8 bits.
      bus_addr_next = {page_next, idx_next};
    end else if (state_next == ST_WRITE) begin
      bus_addr_next = P_oam_port;
      bus_data_next = data_next;
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_reg    <= ST_IDLE;
      page_reg     <= 8'd0;
      idx_reg      <= 8'd0;
      data_reg     <= 8'd0;
      parity_reg   <= 1'b0;
      cpu_rdy_reg  <= 1'b1;
      busy_reg     <= 1'b0;
      bus_req_reg  <= 1'b0;
      bus_addr_reg <= 16'h0000;
      bus_rden_reg <= 1'b0;
      bus_wren_reg <= 1'b0;
      bus_data_reg <= 8'h00;
    end else begin
      state_reg    <= state_next;
      page_reg     <= page_next;
      idx_reg      <= idx_next;
      data_reg     <= data_next;
      parity_reg   <= parity_next;
      cpu_rdy_reg  <= cpu_rdy_next;
      busy_reg     <= busy_next;
      bus_req_reg  <= bus_req_next;
      bus_addr_reg <= bus_addr_next;
      bus_rden_reg <= bus_rden_next;
      bus_wren_reg <= bus_wren_next;
      bus_data_reg <= bus_data_next;
    end
  end

  assign O_cpu_rdy  = cpu_rdy_reg;
  assign O_busy     = busy_reg;
  assign O_bus_req  = bus_req_reg;
  assign O_bus_addr = bus_addr_reg;
  assign O_bus_rden = bus_rden_reg;
  assign O_bus_wren = bus_wren_reg;
  assign O_bus_data = bus_data_reg;

endmodule

// File: tb/tb_video_oam_dma.sv
// Testbench for video_oam_dma: directed transfers checked every clock
// against a transaction-level model, plus literal totals per transfer.
module tb_video_oam_dma;

  logic        clk = 1'b0;
  logic        rst, tick, reg_wren, cpu_read;
  logic [7:0]  reg_data, bus_rdata, bus_wdata;
  logic        cpu_rdy, busy, bus_req, bus_rden, bus_wren;
  logic [15:0] bus_addr;

  always #5 clk = ~clk;

  // Bus model: memory byte at address A holds A[7:0] ^ 8'h5A.
  assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

  video_oam_dma dut (
    .I_clock   (clk),
    .I_reset   (rst),
    .I_tick    (tick),
    .I_reg_wren(reg_wren),
    .I_reg_data(reg_data),
    .I_cpu_read(cpu_read),
    .O_cpu_rdy (cpu_rdy),
    .O_busy    (busy),
    .O_bus_req (bus_req),
    .O_bus_addr(bus_addr),
    .O_bus_rden(bus_rden),
    .O_bus_wren(bus_wren),
    .I_bus_data(bus_rdata),
    .O_bus_data(bus_wdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Output record: {rdy, busy, req, rden, wren, addr[15:0], data[7:0]}
  typedef logic [28:0] rec_t;
  localparam rec_t IDLE_REC = {1'b1, 28'd0};
  localparam rec_t HALT_REC = {1'b0, 1'b1, 27'd0};

  // ---------------- model ----------------
  // A transfer is: some HALT bus cycles, an optional ALIGN cycle, then 512
  // data-phase cycles j=0..511 (even j reads byte j/2, odd j writes it).
  // Reads must sit on bus cycles whose tick count since reset is even.
  rec_t       m_cur = IDLE_REC;
  int         m_ticks = 0;
  int         m_j = 0;
  bit         m_active = 0;
  bit         m_wait = 0;
  logic [7:0] m_page = 8'h00;

  function automatic rec_t phase_rec(input int j, input logic [7:0] page);
    logic [7:0] b;
    if (j < 0) return {1'b0, 1'b1, 1'b1, 26'd0};
    b = 8'(j / 2);
    if (j % 2 == 0) return {1'b0, 1'b1, 3'b110, page, b, 8'h00};
    return {1'b0, 1'b1, 3'b101, 16'h2004, b ^ 8'h5A};
  endfunction

  task automatic model_step();
    int par;
    if (rst) begin
      m_ticks = 0; m_active = 0; m_wait = 0; m_j = 0; m_page = 8'h00;
      m_cur = IDLE_REC;
    end else if (tick) begin
      m_ticks++;
      par = m_ticks % 2;
      if (!m_active) begin
        if (reg_wren) begin
          m_active = 1; m_wait = 1; m_page = reg_data; m_cur = HALT_REC;
        end else begin
          m_cur = IDLE_REC;
        end
      end else if (m_wait) begin
        if (cpu_read) begin
          m_wait = 0;
          m_j = (par == 0) ? 0 : -1;
          m_cur = phase_rec(m_j, m_page);
        end else begin
          m_cur = HALT_REC;
        end
      end else begin
        m_j++;
        if (m_j >= 512) begin
          m_active = 0; m_cur = IDLE_REC;
        end else begin
          m_cur = phase_rec(m_j, m_page);
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare + statistics ----------------
  bit          chk_en = 0;
  int          stall_cnt, align_cnt, wr_edges, done_cnt, page7_reads;
  bit          first_rd_seen;
  logic [15:0] first_rd_addr;
  logic        wren_d = 1'b0, busy_d = 1'b0;

  task automatic clear_stats();
    stall_cnt = 0; align_cnt = 0; wr_edges = 0; done_cnt = 0; page7_reads = 0;
    first_rd_seen = 0; first_rd_addr = 16'h0000;
  endtask

  initial forever begin
    rec_t act, mask;
    @(negedge clk);
    if (chk_en) begin
      act  = {cpu_rdy, busy, bus_req, bus_rden, bus_wren, bus_addr, bus_wdata};
      mask = '1;
      // Address and data only mean something when a bus cycle uses them.
      if (m_cur[27] && !m_cur[25] && !m_cur[24]) mask[23:8] = '0;
      if (m_cur[27] && !m_cur[24]) mask[7:0] = '0;
      check($sformatf("cycle@%0t", $time), 32'(act & mask), 32'(m_cur & mask));

      if (tick && !cpu_rdy) stall_cnt++;
      if (tick && bus_req && !bus_rden && !bus_wren) align_cnt++;
      if (bus_wren && !wren_d) wr_edges++;
      if (!busy && busy_d) done_cnt++;
      if (bus_rden && bus_addr[15:8] == 8'h07) page7_reads++;
      if (bus_rden && !first_rd_seen) begin
        first_rd_seen = 1; first_rd_addr = bus_addr;
      end
    end
    wren_d = bus_wren;
    busy_d = busy;
  end

  // ---------------- stimulus ----------------
  int tb_ticks = 0;

  // One bus cycle = two clocks, tick high for the first.
  task automatic cyc(input logic w, input logic [7:0] d, input logic rd);
    reg_wren = w; reg_data = d; cpu_read = rd; tick = 1'b1;
    @(posedge clk); #1;
    tb_ticks++;
    tick = 1'b0; reg_wren = 1'b0;
    @(posedge clk); #1;
  endtask

  // Make the next tick's index odd (-> 513) or even (-> 514).
  task automatic align_next(input bit want_odd);
    if (((tb_ticks + 1) % 2 == 1) != want_odd) cyc(1'b0, 8'h00, 1'b1);
  endtask

  task automatic run_to_done(input string name);
    for (int i = 0; i < 700; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (!busy) break;
    end
    check({name, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; reg_wren = 1'b0; reg_data = 8'h00; cpu_read = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1;
    check("reset_outputs", 32'({cpu_rdy, busy, bus_req, bus_rden, bus_wren, bus_addr, bus_wdata}),
          32'(IDLE_REC));

    // Idle ticks
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    check("idle_stall", stall_cnt, 0);
    check("idle_busy", 32'(busy), 32'd0);

    // Even-aligned transfer of page 02
    clear_stats();
    align_next(1);
    cyc(1'b1, 8'h02, 1'b1);
    run_to_done("t2");
    check("t2_stall", stall_cnt, 513);
    check("t2_align", align_cnt, 0);
    check("t2_wr_edges", wr_edges, 256);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_first_rd", 32'(first_rd_addr), 32'h0200);

    // Odd-aligned transfer: one ALIGN cycle
    clear_stats();
    align_next(0);
    cyc(1'b1, 8'h02, 1'b1);
    run_to_done("t3");
    check("t3_stall", stall_cnt, 514);
    check("t3_align", align_cnt, 1);
    check("t3_wr_edges", wr_edges, 256);

    // CPU writing for 3 bus cycles keeps the DMA in HALT
    clear_stats();
    align_next(1);
    cyc(1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
    run_to_done("t4");
    check("t4_stall", stall_cnt, 517);
    check("t4_align", align_cnt, 1);

    // Page write while busy is ignored
    clear_stats();
    align_next(1);
    cyc(1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 100; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h07, 1'b1);
    run_to_done("t5");
    check("t5_stall", stall_cnt, 513);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_page7_reads", page7_reads, 0);
    check("t5_wr_edges", wr_edges, 256);

    // Reset (together with a tick) in the READ of byte 0x80
    clear_stats();
    align_next(1);
    cyc(1'b1, 8'h02, 1'b1);
    for (int i = 0; i < 600; i++) begin
      if (bus_rden && bus_addr == 16'h0280) break;
      cyc(1'b0, 8'h00, 1'b1);
    end
    check("t6_reached_0280", 32'({bus_rden, bus_addr}), 32'h10280);
    rst = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tick = 1'b0;
    tb_ticks = 0;
    check("t6_reset_outputs", 32'({cpu_rdy, busy, bus_req, bus_rden, bus_wren, bus_addr, bus_wdata}),
          32'(IDLE_REC));
    @(posedge clk); #1;
    clear_stats();
    cyc(1'b1, 8'h03, 1'b1);
    run_to_done("t6");
    check("t6_first_rd", 32'(first_rd_addr), 32'h0300);
    check("t6_stall", stall_cnt, 513);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
